div4_seq: RTL and testbench

Sequential 4-bit unsigned restoring divider that sits directly around the team's 4-bit subtractor `Sub`. It drives the subtractor's operands once per cycle and consumes its difference and borrow outputs. A start/busy/done handshake lets a controller launch a division and collect a registered quotient, remainder and divide-by-zero flag.

---
 rtl/div4_seq_pkg.sv | 15 +
 rtl/div4_seq_if.sv | 25 ++
 rtl/div4_seq_sub.sv | 16 +
 rtl/div4_seq.sv | 115 +++++++++++
 tb/tb_div4_seq.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/div4_seq_pkg.sv
// Shared definitions for the 4-bit sequential restoring divider:
// state encodings, operand geometry and the divide-by-zero quotient.
package div_defs;

    localparam int WIDTH = 4;
    localparam int ITER  = 4;
    localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div4_seq_if.sv
// Start/busy/done handshake and result bus between a controller (master)
// and the divider (slave).
interface div4_seq_if;
    import div_defs::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div4_seq_sub.sv
// The team's 4-bit combinational subtractor: sum = val0 - val1 (mod 16),
// carry = 1 when the subtraction borrows (val0 < val1).
module Sub (
    input  logic [3:0] val0,
    input  logic [3:0] val1,
    output logic [3:0] sum,
    output logic       carry
);

    logic [4:0] wide_diff;

    assign wide_diff = {1'b0, val0} - {1'b0, val1};
    assign sum       = wide_diff[3:0];
    assign carry     = wide_diff[4];

endmodule

// File: rtl/div4_seq.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per cycle
// through the shared Sub subtractor, results registered on entry to DONE.
module div4_seq
    import div_defs::*;
#(
    parameter int WIDTH = div_defs::WIDTH,
    parameter int ITER  = div_defs::ITER
) (
    input  logic         clk,
    input  logic         rst_n,
    div4_seq_if.slave    bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             qbit;
    logic [WIDTH-1:0] next_r;
    logic [WIDTH-1:0] next_q;

    // The bit shifted out of R means the true partial value is >= 16 > D,
    // so the subtract must succeed regardless of the 4-bit borrow.
    assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign qbit    = r_q[WIDTH-1] | ~borrow;
    assign next_r  = qbit ? diff : shifted;
    assign next_q  = {q_q[WIDTH-2:0], qbit};

    Sub u_sub (
        .val0  (shifted),
        .val1  (d_q),
        .sum   (diff),
        .carry (borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quo_d   = DBZ_QUOTIENT;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        r_d     = '0;
                        q_d     = bus.dividend;
                        d_d     = bus.divisor;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                r_d   = next_r;
                q_d   = next_q;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(ITER - 1)) begin
                    state_d = DONE;
                    quo_d   = next_q;
                    rem_d   = next_r;
                    dbz_d   = 1'b0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div4_seq.sv
// Self-checking bench for div4_seq: directed corner cases, an exhaustive
// operand sweep and random operands against an arithmetic reference model.
module tb_div4_seq;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    div4_seq_if bus ();

    div4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Division defined straight from unsigned arithmetic.
    task automatic model(input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] eq, output logic [3:0] er, output logic edbz);
        if (b == 4'd0) begin
            eq = 4'hF; er = a; edbz = 1'b1;
        end else begin
            eq = a / b; er = a % b; edbz = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag, input logic [3:0] eq, input logic [3:0] er);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_quot"}, 32'(bus.quotient), 32'(eq));
        checkOutput({tag, "_rem"},  32'(bus.remainder), 32'(er));
    endtask

    // Launches one division from IDLE (called just after an edge) and checks
    // latency, busy window, results and the return to IDLE.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] eq, er;
        logic       edbz;
        int         cyc, busyCnt, overlap;
        model(a, b, eq, er, edbz);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        tick();
        bus.start = 1'b0;
        bus.dividend = 4'($urandom_range(15)); bus.divisor = 4'($urandom_range(15));
        cyc = 1; busyCnt = 0; overlap = 0;
        if (bus.busy) busyCnt++;
        while (!bus.done && cyc < 12) begin
            tick();
            cyc++;
            if (bus.busy) busyCnt++;
            if (bus.busy && bus.done) overlap++;
        end
        checkOutput($sformatf("lat_%0d_%0d", a, b), 32'(cyc), (b == 4'd0) ? 32'd1 : 32'd5);
        checkOutput($sformatf("busycnt_%0d_%0d", a, b), 32'(busyCnt), (b == 4'd0) ? 32'd0 : 32'd4);
        checkOutput("busy_done_overlap", 32'(overlap), 32'd0);
        checkOutput($sformatf("quot_%0d_%0d", a, b), 32'(bus.quotient), 32'(eq));
        checkOutput($sformatf("rem_%0d_%0d", a, b), 32'(bus.remainder), 32'(er));
        checkOutput($sformatf("dbz_%0d_%0d", a, b), 32'(bus.div_by_zero), 32'(edbz));
        tick();
        checkIdleOutputs("post_done", eq, er);
    endtask

    initial begin
        int doneCnt;
        total = 0;
        bad   = 0;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        #12;
        checkIdleOutputs("reset", 4'd0, 4'd0);
        checkOutput("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] directed cases");
        applyStimulus(4'd13, 4'd3);
        applyStimulus(4'd15, 4'd1);
        applyStimulus(4'd7, 4'd9);
        applyStimulus(4'd15, 4'd15);
        applyStimulus(4'd8, 4'd15);
        applyStimulus(4'd9, 4'd0);
        applyStimulus(4'd6, 4'd2);

        $display("[TB] start while busy");
        bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
        tick();
        bus.start = 1'b0;
        doneCnt = 0;
        tick();
        bus.start = 1'b1; bus.dividend = 4'd5; bus.divisor = 4'd1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                doneCnt++;
                checkOutput("busy_start_quot", 32'(bus.quotient), 32'd4);
                checkOutput("busy_start_rem", 32'(bus.remainder), 32'd1);
            end
            tick();
        end
        checkOutput("busy_start_done_count", 32'(doneCnt), 32'd1);
        checkIdleOutputs("busy_start_after", 4'd4, 4'd1);

        $display("[TB] reset mid-operation");
        bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd4;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midreset", 4'd0, 4'd0);
        checkOutput("midreset_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done) doneCnt++;
        end
        checkOutput("midreset_no_done", 32'(doneCnt), 32'd0);
        applyStimulus(4'd14, 4'd4);

        $display("[TB] hold");
        applyStimulus(4'd13, 4'd3);
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) doneCnt++;
            if (bus.quotient !== 4'd4 || bus.remainder !== 4'd1)
                checkOutput("hold_value", {24'd0, bus.quotient, bus.remainder}, 32'h41);
        end
        checkOutput("hold_no_done", 32'(doneCnt), 32'd0);
        checkIdleOutputs("hold_end", 4'd4, 4'd1);

        $display("[TB] exhaustive sweep");
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                applyStimulus(4'(a), 4'(b));

        $display("[TB] random operands");
        for (int i = 0; i < 40; i++)
            applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
